vram_arbiter: RTL and testbench

VRAM_ARBITER -- requirements
Module: vram_arbiter

---
 rtl/vram_pkg.sv | 25 ++
 rtl/vram_arbiter.sv | 138 +++++++++++++
 tb/tb_vram_arbiter.sv | 416 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vram_pkg.sv
// vram_pkg: shared types and timing constants for the VRAM arbiter.
// Access lengths are in clock cycles, first state to last state.
package vram_pkg;

    typedef enum logic [2:0] {
        IDLE,
        VRD1,
        VRD2,
        CRD1,
        CRD2,
        CWR1,
        CWR2,
        CWR3
    } state_t;

    typedef logic [1:0] lane_t;

    localparam int T_RD = 2;
    localparam int T_WR = 3;

    function automatic logic [3:0] lane_mask(lane_t l);
        return 4'b0001 << l;
    endfunction

endpackage

// File: rtl/vram_arbiter.sv
// vram_arbiter: shares one 32-bit SRAM bank between video fetch and
// byte-wide CPU access; all SRAM pins are registered.
module vram_arbiter
    import vram_pkg::*;
#(
    parameter int FAIR_LIMIT = 4
) (
    input  logic        tg42,
    input  logic        n_reset,
    input  logic        vid_req,
    input  logic [16:0] vid_addr,
    output logic        vid_valid,
    output logic [31:0] vid_data,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [18:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic        cpu_ack,
    output logic [7:0]  cpu_rdata,
    output logic [1:0]  n_vcs,
    output logic [15:0] va,
    output logic [3:0]  n_vwr,
    output logic [31:0] vd_o,
    output logic [3:0]  vd_oe,
    input  logic [31:0] vd_i
);

    localparam int FW = $clog2(FAIR_LIMIT + 1);
    localparam logic [FW-1:0] FAIR_MAX = FW'(FAIR_LIMIT);

    state_t        state;
    state_t        nxt;
    logic [FW-1:0] fair_cnt;
    logic          rdy;
    logic          sel;
    logic          nxt_sel;
    lane_t         lane;
    lane_t         nxt_lane;
    logic          arb;
    logic          vid_pend;
    logic          cpu_pend;
    logic          cpu_win;
    logic          gnt_vid;
    logic          gnt_cpu;
    logic          nxt_wr;

    // A requester whose completion is pulsing this cycle is not re-granted.
    assign vid_pend = vid_req && !vid_valid;
    assign cpu_pend = cpu_req && !cpu_ack;

    assign arb = rdy && (state == IDLE || state == VRD2 ||
                         state == CRD2 || state == CWR3);

    assign cpu_win = cpu_pend && (!vid_pend || fair_cnt == FAIR_MAX);
    assign gnt_vid = arb && vid_pend && !cpu_win;
    assign gnt_cpu = arb && cpu_win;

    assign nxt_wr = (nxt == CWR1) || (nxt == CWR2) || (nxt == CWR3);

    always_comb begin
        nxt      = state;
        nxt_sel  = sel;
        nxt_lane = lane;
        unique case (1'b1)
            gnt_vid: begin
                nxt     = VRD1;
                nxt_sel = vid_addr[16];
            end
            gnt_cpu: begin
                nxt      = cpu_we ? CWR1 : CRD1;
                nxt_sel  = cpu_addr[18];
                nxt_lane = cpu_addr[1:0];
            end
            default: begin
                unique case (state)
                    VRD1:    nxt = VRD2;
                    CRD1:    nxt = CRD2;
                    CWR1:    nxt = CWR2;
                    CWR2:    nxt = CWR3;
                    default: nxt = IDLE;
                endcase
            end
        endcase
    end

    always_ff @(posedge tg42 or negedge n_reset) begin
        if (!n_reset) begin
            state     <= IDLE;
            rdy       <= 1'b0;
            fair_cnt  <= '0;
            sel       <= 1'b0;
            lane      <= '0;
            n_vcs     <= 2'b11;
            n_vwr     <= 4'hF;
            vd_oe     <= 4'h0;
            va        <= '0;
            vd_o      <= '0;
            vid_valid <= 1'b0;
            cpu_ack   <= 1'b0;
            vid_data  <= '0;
            cpu_rdata <= '0;
        end else begin
            state <= nxt;
            rdy   <= 1'b1;
            sel   <= nxt_sel;
            lane  <= nxt_lane;

            if (!cpu_req || gnt_cpu)
                fair_cnt <= '0;
            else if (gnt_vid && fair_cnt != FAIR_MAX)
                fair_cnt <= fair_cnt + 1'b1;

            if (gnt_vid)
                va <= vid_addr[15:0];
            else if (gnt_cpu)
                va <= cpu_addr[17:2];

            if (gnt_cpu && cpu_we)
                vd_o <= {4{cpu_wdata}};

            // Pins reflect the state being entered, so they are
            // valid for the whole of each access cycle.
            n_vcs <= (nxt == IDLE) ? 2'b11
                   : (nxt_sel ? 2'b01 : 2'b10);
            n_vwr <= (nxt == CWR2) ? ~lane_mask(nxt_lane) : 4'hF;
            vd_oe <= nxt_wr ? lane_mask(nxt_lane) : 4'h0;

            vid_valid <= (state == VRD2);
            cpu_ack   <= (state == CRD2) || (state == CWR3);

            if (state == VRD2)
                vid_data <= vd_i;
            if (state == CRD2)
                cpu_rdata <= vd_i[8*lane +: 8];
        end
    end

endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: directed and randomized stimulus checked every cycle
// against a transaction-level model of the arbiter.
module tb_vram_arbiter;
    import vram_pkg::*;

    localparam int LIM = 4;

    logic        tg42 = 1'b0;
    logic        n_reset = 1'b1;
    logic        vid_req = 1'b0;
    logic [16:0] vid_addr = '0;
    logic        vid_valid;
    logic [31:0] vid_data;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic [18:0] cpu_addr = '0;
    logic [7:0]  cpu_wdata = '0;
    logic        cpu_ack;
    logic [7:0]  cpu_rdata;
    logic [1:0]  n_vcs;
    logic [15:0] va;
    logic [3:0]  n_vwr;
    logic [31:0] vd_o;
    logic [3:0]  vd_oe;
    logic [31:0] vd_i = '0;

    vram_arbiter #(.FAIR_LIMIT(LIM)) dut (
        .tg42      (tg42),
        .n_reset   (n_reset),
        .vid_req   (vid_req),
        .vid_addr  (vid_addr),
        .vid_valid (vid_valid),
        .vid_data  (vid_data),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_ack   (cpu_ack),
        .cpu_rdata (cpu_rdata),
        .n_vcs     (n_vcs),
        .va        (va),
        .n_vwr     (n_vwr),
        .vd_o      (vd_o),
        .vd_oe     (vd_oe),
        .vd_i      (vd_i)
    );

    always #5 tg42 = ~tg42;

    int checks = 0;
    int failures = 0;

    // Model: kind 0 none, 1 video read, 2 cpu read, 3 cpu write.
    int          m_kind;
    int          m_left;
    int          m_pos;
    int          m_fair;
    bit          m_rdy;
    logic        m_sel;
    logic [1:0]  m_lane;
    logic [15:0] m_va;
    logic [31:0] m_vdo;
    logic        e_vv;
    logic        e_ack;
    logic [31:0] e_vdata;
    logic [7:0]  e_rdata;

    int cyc;
    int ev_kind[$];
    int ev_cyc[$];

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t",
                     tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_kind  = 0;
        m_left  = 0;
        m_pos   = 0;
        m_fair  = 0;
        m_rdy   = 0;
        m_sel   = 1'b0;
        m_lane  = '0;
        m_va    = '0;
        m_vdo   = '0;
        e_vv    = 1'b0;
        e_ack   = 1'b0;
        e_vdata = '0;
        e_rdata = '0;
    endtask

    task automatic model_edge(input logic vr,
                              input logic [16:0] vadr,
                              input logic cr,
                              input logic cwe,
                              input logic [18:0] cadr,
                              input logic [7:0] cwd,
                              input logic [31:0] vdi);
        bit last, free, vp, cp, cwin, gv, gc;
        last = (m_kind != 0) && (m_left == 1);
        free = m_rdy && (m_kind == 0 || last);
        vp   = vr && !e_vv;
        cp   = cr && !e_ack;
        cwin = cp && (!vp || m_fair == LIM);
        gv   = free && vp && !cwin;
        gc   = free && cwin;
        e_vv  = last && m_kind == 1;
        e_ack = last && m_kind >= 2;
        if (last && m_kind == 1)
            e_vdata = vdi;
        if (last && m_kind == 2)
            e_rdata = vdi[8*m_lane +: 8];
        if (!cr || gc)
            m_fair = 0;
        else if (gv && m_fair < LIM)
            m_fair++;
        if (gv) begin
            m_kind = 1;
            m_left = T_RD;
            m_pos  = 0;
            m_sel  = vadr[16];
            m_va   = vadr[15:0];
        end else if (gc) begin
            m_kind = cwe ? 3 : 2;
            m_left = cwe ? T_WR : T_RD;
            m_pos  = 0;
            m_sel  = cadr[18];
            m_lane = cadr[1:0];
            m_va   = cadr[17:2];
            if (cwe)
                m_vdo = {4{cwd}};
        end else if (last) begin
            m_kind = 0;
        end else if (m_kind != 0) begin
            m_left--;
            m_pos++;
        end
        m_rdy = 1;
    endtask

    task automatic check_pins();
        logic [3:0] oh;
        logic [3:0] ewr;
        logic [3:0] eoe;
        logic [1:0] ecs;
        oh  = 4'b0001 << m_lane;
        ewr = (m_kind == 3 && m_pos == 1) ? ~oh : 4'hF;
        eoe = (m_kind == 3) ? oh : 4'h0;
        ecs = (m_kind == 0) ? 2'b11 : (m_sel ? 2'b01 : 2'b10);
        chk("vid_valid", 32'(vid_valid), 32'(e_vv));
        chk("cpu_ack", 32'(cpu_ack), 32'(e_ack));
        chk("vid_data", vid_data, e_vdata);
        chk("cpu_rdata", 32'(cpu_rdata), 32'(e_rdata));
        chk("va", 32'(va), 32'(m_va));
        chk("vd_o", vd_o, m_vdo);
        chk("n_vcs", 32'(n_vcs), 32'(ecs));
        chk("n_vwr", 32'(n_vwr), 32'(ewr));
        chk("vd_oe", 32'(vd_oe), 32'(eoe));
    endtask

    task automatic tick();
        logic        vr, cr, cwe;
        logic [16:0] vadr;
        logic [18:0] cadr;
        logic [7:0]  cwd;
        logic [31:0] vdi;
        vr   = vid_req;
        vadr = vid_addr;
        cr   = cpu_req;
        cwe  = cpu_we;
        cadr = cpu_addr;
        cwd  = cpu_wdata;
        vdi  = vd_i;
        @(posedge tg42);
        if (n_reset)
            model_edge(vr, vadr, cr, cwe, cadr, cwd, vdi);
        #1;
        cyc++;
        check_pins();
        if (vid_valid) begin
            ev_kind.push_back(1);
            ev_cyc.push_back(cyc);
        end
        if (cpu_ack) begin
            ev_kind.push_back(2);
            ev_cyc.push_back(cyc);
        end
    endtask

    task automatic start();
        cyc = 0;
        ev_kind.delete();
        ev_cyc.delete();
    endtask

    function automatic int ev_at(input int kind, input int nth);
        int n;
        n = 0;
        foreach (ev_kind[i]) begin
            if (ev_kind[i] == kind) begin
                if (n == nth)
                    return ev_cyc[i];
                n++;
            end
        end
        return -1;
    endfunction

    task automatic hard_reset(input int n);
        n_reset = 1'b0;
        #1;
        model_reset();
        check_pins();
        repeat (n) tick();
        n_reset = 1'b1;
    endtask

    task automatic drain();
        vid_req = 1'b0;
        cpu_req = 1'b0;
        for (int i = 0; i < 20 && (m_kind != 0 || e_vv || e_ack); i++)
            tick();
        tick();
        tick();
    endtask

    initial begin
        int nwr_cnt, nwr_cyc;
        logic [3:0] nwr_val;
        logic [3:0] exp_wr;

        model_reset();
        #1;
        hard_reset(2);
        tick();

        // Video-only fetch from chip pair 1.
        start();
        vid_addr = 17'h1_0040;
        vd_i = 32'hDEADBEEF;
        vid_req = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (cyc <= 2) begin
                chk("d1_n_vcs", 32'(n_vcs), 32'(2'b01));
                chk("d1_va", 32'(va), 32'h0040);
            end
            if (vid_valid)
                vid_req = 1'b0;
        end
        chk("d1_latency", ev_at(1, 0), 3);
        chk("d1_vid_data", vid_data, 32'hDEADBEEF);
        drain();

        // CPU byte write to lane 2, chip pair 0.
        start();
        cpu_addr = 19'h0_0106;
        cpu_wdata = 8'hA5;
        cpu_we = 1'b1;
        cpu_req = 1'b1;
        nwr_cnt = 0;
        nwr_cyc = 0;
        nwr_val = 4'hF;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (cyc == 1) begin
                chk("d2_va", 32'(va), 32'h0041);
                chk("d2_n_vcs", 32'(n_vcs), 32'(2'b10));
                chk("d2_vd_oe", 32'(vd_oe), 32'(4'b0100));
            end
            if (cyc <= 4 && n_vwr != 4'hF) begin
                nwr_cnt++;
                nwr_cyc = cyc;
                nwr_val = n_vwr;
            end
            if (cpu_ack)
                cpu_req = 1'b0;
        end
        chk("d2_strobe_cnt", nwr_cnt, 1);
        chk("d2_strobe_cyc", nwr_cyc, 2);
        chk("d2_strobe_val", 32'(nwr_val), 32'(4'b1011));
        chk("d2_ack_lat", ev_at(2, 0), 4);
        drain();

        // CPU read of lane 3 on chip pair 1.
        start();
        cpu_addr = 19'h4_0003;
        cpu_we = 1'b0;
        vd_i = 32'h12345678;
        cpu_req = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (cyc == 1)
                chk("d3_n_vcs", 32'(n_vcs), 32'(2'b01));
            if (cpu_ack)
                cpu_req = 1'b0;
        end
        chk("d3_ack_lat", ev_at(2, 0), 3);
        chk("d3_rdata", 32'(cpu_rdata), 32'h12);
        drain();

        // Continuous video with a CPU read waiting: four video, one CPU.
        start();
        vid_addr = 17'(32'h0_2222);
        cpu_addr = 19'(32'h1_1111);
        cpu_we = 1'b0;
        vd_i = 32'hCAFEF00D;
        vid_req = 1'b1;
        cpu_req = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (cpu_ack)
                cpu_req = 1'b0;
        end
        chk("d4_vid4", ev_at(1, 3), 9);
        chk("d4_cpu", ev_at(2, 0), 11);
        chk("d4_vid5", ev_at(1, 4), 13);
        drain();

        // Simultaneous requests from idle: video goes first.
        start();
        vid_req = 1'b1;
        cpu_req = 1'b1;
        for (int i = 0; i < 14; i++) begin
            tick();
            if (vid_valid)
                vid_req = 1'b0;
            if (cpu_ack)
                cpu_req = 1'b0;
        end
        chk("d6_vid_first", ev_at(1, 0), 3);
        chk("d6_cpu_after",
            32'(ev_at(2, 0) > ev_at(1, 0)), 32'd1);
        drain();

        // Reset in the middle of a write strobe.
        start();
        cpu_addr = 19'h2_1235;
        cpu_wdata = 8'h3C;
        cpu_we = 1'b1;
        cpu_req = 1'b1;
        tick();
        tick();
        exp_wr = ~(4'b0001 << cpu_addr[1:0]);
        chk("d5_strobe", 32'(n_vwr), 32'(exp_wr));
        n_reset = 1'b0;
        #1;
        chk("d5_rst_nvwr", 32'(n_vwr), 32'hF);
        chk("d5_rst_oe", 32'(vd_oe), 32'h0);
        model_reset();
        check_pins();
        start();
        tick();
        tick();
        n_reset = 1'b1;
        chk("d5_no_ack", ev_at(2, 0), -1);
        start();
        tick();
        chk("d5_first_edge", 32'(n_vcs), 32'(2'b11));
        for (int i = 0; i < 8; i++) begin
            if (cpu_ack)
                cpu_req = 1'b0;
            tick();
        end
        chk("d5_reissue", ev_at(2, 0), 5);
        drain();

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 1500; i++) begin
            if (!vid_req) begin
                if ($urandom_range(3) == 0) begin
                    vid_req = 1'b1;
                    vid_addr = 17'($urandom);
                end
            end else if (vid_valid) begin
                if ($urandom_range(1) == 0)
                    vid_req = 1'b0;
                else
                    vid_addr = 17'($urandom);
            end
            if (!cpu_req) begin
                if ($urandom_range(2) == 0) begin
                    cpu_req = 1'b1;
                    cpu_we = 1'($urandom);
                    cpu_addr = 19'($urandom);
                    cpu_wdata = 8'($urandom);
                end
            end else if (cpu_ack) begin
                if ($urandom_range(1) == 0) begin
                    cpu_req = 1'b0;
                end else begin
                    cpu_we = 1'($urandom);
                    cpu_addr = 19'($urandom);
                    cpu_wdata = 8'($urandom);
                end
            end
            vd_i = $urandom;
            if ($urandom_range(299) == 0)
                hard_reset(2);
            else
                tick();
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
